// File: rtl/led_pattern_pkg.sv
// -----------------------------------------------------------------------------
// led_pattern_pkg
// Shared types and constants for the LED pattern sequencer.
//   state_e : sequencer states (IDLE, RUN, DONE)
//   dir_e   : bounce travel direction
//   MODE_*  : 2-bit pattern select codes carried on the mode input
// -----------------------------------------------------------------------------
package led_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [1:0] MODE_WALK   = 2'd0;
    localparam logic [1:0] MODE_BOUNCE = 2'd1;
    localparam logic [1:0] MODE_COUNT  = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

endpackage : led_pattern_pkg

// File: rtl/rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// Turns a level that is already synchronous to clock_in into a one-cycle
// strobe on each rising edge. Usable for divider ticks or debounced buttons.
//   clock_in : system clock
//   rst_n    : asynchronous active-low reset (history register clears to 0)
//   sig_i    : synchronous input level
//   rise_o   : high for one cycle when sig_i is 1 and was 0 last cycle
// -----------------------------------------------------------------------------
module rise_detect (
    input  logic clock_in,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule : rise_detect

// File: rtl/led_pattern_seq.sv
// -----------------------------------------------------------------------------
// led_pattern_seq
// Animates a bank of LEDs from the clock divider's slow square wave. Each
// rising edge of tick_in (seen in the clock_in domain) advances the selected
// pattern by one step; a run lasts STEPS updates, or forever when STEPS = 0.
//
// Parameters:
//   WIDTH : number of LEDs (>= 2)
//   STEPS : updates per run, 0 = run until stop
// Ports:
//   clock_in : system clock, same as the divider
//   rst_n    : asynchronous active-low reset
//   tick_in  : divided clock, already registered in the clock_in domain
//   start    : one-cycle run request, honoured in IDLE only
//   stop     : abort request, honoured in RUN only
//   mode     : pattern select latched at start (walk/bounce/count/blink)
//   led      : current pattern
//   busy     : high while running
//   done     : one-cycle pulse after a run completes normally
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; led holds last pattern (or 0 after stop)
// RUN   | advancing the pattern on each tick rising edge
// DONE  | single cycle after the final update; done pulses here
// -----------------------------------------------------------------------------
module led_pattern_seq
    import led_pattern_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEPS = 16
) (
    input  logic             clock_in,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] led,
    output logic             busy,
    output logic             done
);

    // Counter must hold the value STEPS itself; one bit minimum when unused.
    localparam int CNT_W = (STEPS < 1) ? 1 : $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  led_q, led_d;
    dir_e              dir_q, dir_d;
    logic [1:0]        mode_q, mode_d;
    logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              step;
    logic [WIDTH-1:0]  pat_next;
    dir_e              pat_dir;
    logic [CNT_W-1:0]  cnt_next;

    // tick history runs in every state, so a tick already high at start
    // produces no step until it falls and rises again.
    rise_detect u_rise (
        .clock_in (clock_in),
        .rst_n    (rst_n),
        .sig_i    (tick_in),
        .rise_o   (step)
    );

    function automatic logic [WIDTH-1:0] init_pattern(input logic [1:0] m);
        case (m)
            MODE_WALK,
            MODE_BOUNCE: return WIDTH'(1);
            MODE_COUNT:  return '0;
            default:     return '1;
        endcase
    endfunction

    // Pattern update for the latched mode.
    always_comb begin
        pat_next = led_q;
        pat_dir  = dir_q;
        case (mode_q)
            MODE_WALK: begin
                pat_next = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
            end
            MODE_BOUNCE: begin
                // Direction flips on arrival at an end, so the end bit is
                // shown once and the next step already heads back.
                if (dir_q == DIR_LEFT) begin
                    pat_next = led_q << 1;
                    if (pat_next[WIDTH-1]) begin
                        pat_dir = DIR_RIGHT;
                    end
                end else begin
                    pat_next = led_q >> 1;
                    if (pat_next[0]) begin
                        pat_dir = DIR_LEFT;
                    end
                end
            end
            MODE_COUNT: begin
                pat_next = led_q + WIDTH'(1);
            end
            default: begin
                pat_next = ~led_q;
            end
        endcase
    end

    assign cnt_next = step_cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        led_d      = led_q;
        dir_d      = dir_q;
        mode_d     = mode_q;
        step_cnt_d = step_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    mode_d     = mode;
                    led_d      = init_pattern(mode);
                    dir_d      = DIR_LEFT;
                    step_cnt_d = '0;
                end
            end
            RUN: begin
                // stop outranks a coincident step, including the final one.
                if (stop) begin
                    state_d = IDLE;
                    led_d   = '0;
                end else if (step) begin
                    led_d = pat_next;
                    dir_d = pat_dir;
                    if (STEPS != 0) begin
                        step_cnt_d = cnt_next;
                        if (cnt_next == CNT_LAST) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flag outputs are registered copies of the next state.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            led_q      <= '0;
            dir_q      <= DIR_LEFT;
            mode_q     <= MODE_WALK;
            step_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            led_q      <= led_d;
            dir_q      <= dir_d;
            mode_q     <= mode_d;
            step_cnt_q <= step_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule : led_pattern_seq

// File: tb/tb_led_pattern_seq.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_seq
// Three sequencer instances share one stimulus stream:
//   a : WIDTH 8, STEPS 16
//   b : WIDTH 4, STEPS 8
//   c : WIDTH 8, STEPS 0 (free running)
// A behavioural model tracks, per instance, whether a run is active, how many
// updates have happened, and derives the expected pattern arithmetically from
// the update count. Outputs are compared every negative clock edge.
// -----------------------------------------------------------------------------
module tb_led_pattern_seq;

    logic       clock_in = 1'b0;
    logic       rst_n;
    logic       tick_in;
    logic       start;
    logic       stop;
    logic [1:0] mode;

    logic [7:0] led_a;
    logic       busy_a, done_a;
    logic [3:0] led_b;
    logic       busy_b, done_b;
    logic [7:0] led_c;
    logic       busy_c, done_c;

    always #5 clock_in = ~clock_in;

    led_pattern_seq #(.WIDTH(8), .STEPS(16)) u_a (
        .clock_in (clock_in), .rst_n (rst_n), .tick_in (tick_in),
        .start (start), .stop (stop), .mode (mode),
        .led (led_a), .busy (busy_a), .done (done_a)
    );

    led_pattern_seq #(.WIDTH(4), .STEPS(8)) u_b (
        .clock_in (clock_in), .rst_n (rst_n), .tick_in (tick_in),
        .start (start), .stop (stop), .mode (mode),
        .led (led_b), .busy (busy_b), .done (done_b)
    );

    led_pattern_seq #(.WIDTH(8), .STEPS(0)) u_c (
        .clock_in (clock_in), .rst_n (rst_n), .tick_in (tick_in),
        .start (start), .stop (stop), .mode (mode),
        .led (led_c), .busy (busy_c), .done (done_c)
    );

    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 1'b0;
    int done_cnt[3];

    // ---------------- behavioural model ----------------
    int mw[3] = '{8, 4, 8};
    int ms[3] = '{16, 8, 0};
    bit m_run[3];
    bit m_done[3];
    bit m_show[3];
    bit m_tprev[3];
    int m_n[3];
    int m_mode[3];

    // Pattern after n updates from the initial pattern of mode md.
    function automatic logic [7:0] pattern(input int md, input int n, input int w);
        int mask;
        int p;
        mask = (1 << w) - 1;
        case (md)
            0: return 8'(1 << (n % w));
            1: begin
                p = n % (2 * w - 2);
                if (p >= w) p = 2 * w - 2 - p;
                return 8'(1 << p);
            end
            2: return 8'(n & mask);
            default: return ((n % 2) == 0) ? 8'(mask) : 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] exp_led(input int i);
        return m_show[i] ? pattern(m_mode[i], m_n[i], mw[i]) : 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_run[i] = 0; m_done[i] = 0; m_show[i] = 0;
            m_tprev[i] = 0; m_n[i] = 0; m_mode[i] = 0;
        end
    endtask

    task automatic model_step();
        bit stp;
        for (int i = 0; i < 3; i++) begin
            stp = tick_in && !m_tprev[i];
            m_tprev[i] = tick_in;
            if (m_done[i]) begin
                m_done[i] = 0;
            end else if (!m_run[i]) begin
                if (start) begin
                    m_run[i]  = 1;
                    m_mode[i] = int'(mode);
                    m_n[i]    = 0;
                    m_show[i] = 1;
                end
            end else if (stop) begin
                m_run[i]  = 0;
                m_show[i] = 0;
            end else if (stp) begin
                m_n[i] = m_n[i] + 1;
                if (ms[i] != 0 && m_n[i] == ms[i]) begin
                    m_run[i]  = 0;
                    m_done[i] = 1;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock_in or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    initial begin
        logic [7:0] al;
        logic ab, ad;
        forever begin
            @(negedge clock_in);
            if (chk_en) begin
                for (int i = 0; i < 3; i++) begin
                    case (i)
                        0:       begin al = led_a;          ab = busy_a; ad = done_a; end
                        1:       begin al = {4'h0, led_b};  ab = busy_b; ad = done_b; end
                        default: begin al = led_c;          ab = busy_c; ad = done_c; end
                    endcase
                    chk($sformatf("led[%0d]", i), al, exp_led(i));
                    chk($sformatf("busy[%0d]", i), {7'h0, ab}, {7'h0, m_run[i]});
                    chk($sformatf("done[%0d]", i), {7'h0, ad}, {7'h0, m_done[i]});
                    if (ad === 1'b1) done_cnt[i]++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    task automatic pulse_start(input logic [1:0] md);
        start = 1'b1;
        mode  = md;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick_in = 1'b1;
            cyc(2);
            tick_in = 1'b0;
            cyc(2);
        end
    endtask

    logic [3:0] bounce_exp [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                   4'b0010, 4'b0001, 4'b0010, 4'b0100};

    initial begin
        rst_n = 1'b1; tick_in = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;

        // Reset held with random inputs.
        @(negedge clock_in);
        repeat (6) begin
            tick_in = 1'($urandom_range(0, 1));
            start   = 1'($urandom_range(0, 1));
            stop    = 1'($urandom_range(0, 1));
            mode    = 2'($urandom_range(0, 3));
            cyc(1);
        end
        chk("reset_led", led_a, 8'h00);
        chk("reset_busy", {7'h0, busy_a}, 8'h00);
        tick_in = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);

        // Idle with ticks and no start.
        ticks(20);
        chk("idle_led", led_a, 8'h00);
        chk("idle_busy", {7'h0, busy_a}, 8'h00);

        // Walk run.
        done_cnt = '{0, 0, 0};
        pulse_start(2'd0);
        chk("walk_init", led_a, 8'h01);
        ticks(16);
        chk("walk_end", led_a, 8'h01);
        chk("walk_done_cnt", 8'(done_cnt[0]), 8'd1);
        chk("walk_busy", {7'h0, busy_a}, 8'h00);
        pulse_stop();

        // Bounce run on the 4-wide instance.
        done_cnt = '{0, 0, 0};
        pulse_start(2'd1);
        for (int k = 0; k < 8; k++) begin
            tick_in = 1'b1;
            cyc(1);
            chk($sformatf("bounce_%0d", k), {4'h0, led_b}, {4'h0, bounce_exp[k]});
            cyc(1);
            tick_in = 1'b0;
            cyc(2);
        end
        chk("bounce_done_cnt", 8'(done_cnt[1]), 8'd1);
        pulse_stop();

        // Count wrap on the free-running instance.
        done_cnt = '{0, 0, 0};
        pulse_start(2'd2);
        ticks(257);
        chk("count_end", led_c, 8'h01);
        chk("count_busy", {7'h0, busy_c}, 8'h01);
        chk("count_no_done", 8'(done_cnt[2]), 8'd0);
        pulse_stop();

        // Blink started with tick already high; stop collides with a step.
        done_cnt = '{0, 0, 0};
        tick_in = 1'b1;
        cyc(2);
        pulse_start(2'd3);
        cyc(3);
        chk("blink_hold", led_a, 8'hFF);
        tick_in = 1'b0;
        cyc(2);
        tick_in = 1'b1;
        cyc(1);
        chk("blink_first", led_a, 8'h00);
        start = 1'b1; mode = 2'd0;
        cyc(1);
        start = 1'b0;
        chk("run_start_ignored", {7'h0, busy_a}, 8'h01);
        cyc(1);
        tick_in = 1'b0;
        cyc(2);
        tick_in = 1'b1;
        cyc(1);
        chk("blink_second", led_a, 8'hFF);
        cyc(1);
        tick_in = 1'b0;
        cyc(2);
        tick_in = 1'b1;
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("stop_led", led_a, 8'h00);
        chk("stop_busy", {7'h0, busy_a}, 8'h00);
        cyc(1);
        tick_in = 1'b0;
        cyc(2);
        chk("stop_no_done", 8'(done_cnt[0]), 8'd0);

        // Reset in the middle of a walk run.
        pulse_start(2'd0);
        ticks(5);
        chk("mid_walk", led_a, 8'h20);
        @(posedge clock_in);
        #2 rst_n = 1'b0;
        #1;
        chk("async_led", led_a, 8'h00);
        chk("async_busy", {7'h0, busy_a}, 8'h00);
        chk("async_done", {7'h0, done_a}, 8'h00);
        @(negedge clock_in);
        rst_n = 1'b1;
        cyc(1);
        pulse_start(2'd0);
        chk("restart_led", led_a, 8'h01);
        chk("restart_busy", {7'h0, busy_a}, 8'h01);
        ticks(2);
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_led_pattern_seq
